// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch path: branch opcodes, the 2-bit
// branch counter type and the default reset PC.
package mips_pkg;

    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_STRONG_NT = 2'b00;
    localparam ctr_t CTR_WEAK_NT   = 2'b01;
    localparam ctr_t CTR_WEAK_T    = 2'b10;
    localparam ctr_t CTR_STRONG_T  = 2'b11;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Saturating step of a 2-bit counter toward the resolved outcome.
    function automatic ctr_t ctr_next(input ctr_t cur, input logic taken);
        ctr_t nxt;
        case (cur)
            CTR_STRONG_NT: nxt = taken ? CTR_WEAK_NT  : CTR_STRONG_NT;
            CTR_WEAK_NT:   nxt = taken ? CTR_WEAK_T   : CTR_STRONG_NT;
            CTR_WEAK_T:    nxt = taken ? CTR_STRONG_T : CTR_WEAK_NT;
            CTR_STRONG_T:  nxt = taken ? CTR_STRONG_T : CTR_WEAK_T;
            default:       nxt = CTR_WEAK_NT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/pht_counter_table.sv
// Pattern history table: array of 2-bit saturating counters with one
// combinational read port and one saturating-update write port.
module pht_counter_table
    import mips_pkg::*;
#(
    parameter int   ENTRIES      = 64,
    parameter int   INDEX_W      = 6,
    parameter ctr_t COUNTER_INIT = CTR_WEAK_NT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INDEX_W-1:0] rd_idx,
    output logic [1:0]         rd_ctr,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_idx,
    input  logic               wr_taken
);

    ctr_t table_r [ENTRIES];

    // Counter storage: bulk re-initialise on reset, otherwise one saturating update.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_r[i] <= COUNTER_INIT;
            end
        end else if (wr_en) begin
            table_r[wr_idx] <= ctr_next(table_r[wr_idx], wr_taken);
        end
    end

    assign rd_ctr = table_r[rd_idx];

endmodule

// File: rtl/if_next_pc_unit.sv
// Instruction-fetch next-PC unit: predicts conditional branches with a PHT,
// selects the next fetch address and recovers from EX-stage mispredictions.
module if_next_pc_unit
    import mips_pkg::*;
#(
    parameter int          PHT_ENTRIES  = 64,
    parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT,
    parameter ctr_t        COUNTER_INIT = CTR_WEAK_NT
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        Stall,
    input  logic [31:0] IF_Instruction,
    input  logic [31:0] Branch_Addr,
    input  logic        EX_Branch,
    input  logic        EX_Taken,
    input  logic        EX_Pred_Taken,
    input  logic [31:0] EX_PC,
    input  logic [31:0] EX_Target,
    output logic [31:0] PC,
    output logic [31:0] PC_4,
    output logic        IF_Pred_Taken,
    output logic        Flush
);

    localparam int INDEX_W = $clog2(PHT_ENTRIES);

    logic [31:0] pc_r;
    logic [31:0] next_pc_s;
    logic [31:0] recovery_pc_s;
    logic [1:0]  rd_ctr_s;
    logic        is_branch_s;
    logic        pred_taken_s;
    logic        mispredict_s;

    pht_counter_table #(
        .ENTRIES      (PHT_ENTRIES),
        .INDEX_W      (INDEX_W),
        .COUNTER_INIT (COUNTER_INIT)
    ) u_pht (
        .clk      (CLK),
        .reset    (RESET),
        .rd_idx   (pc_r[INDEX_W+1:2]),
        .rd_ctr   (rd_ctr_s),
        .wr_en    (EX_Branch),
        .wr_idx   (EX_PC[INDEX_W+1:2]),
        .wr_taken (EX_Taken)
    );

    assign is_branch_s   = (IF_Instruction[31:26] == OP_BEQ) || (IF_Instruction[31:26] == OP_BNE);
    assign pred_taken_s  = is_branch_s && rd_ctr_s[1];
    assign mispredict_s  = EX_Branch && (EX_Taken != EX_Pred_Taken);
    assign recovery_pc_s = EX_Taken ? EX_Target : (EX_PC + 32'd4);

    // Next-PC select; a mispredict redirect outranks the stall hold.
    always_comb begin
        next_pc_s = pc_r + 32'd4;
        if (mispredict_s) begin
            next_pc_s = recovery_pc_s;
        end else if (Stall) begin
            next_pc_s = pc_r;
        end else if (pred_taken_s) begin
            next_pc_s = Branch_Addr;
        end else begin
            next_pc_s = pc_r + 32'd4;
        end
    end

    // Fetch PC register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= next_pc_s;
        end
    end

    assign PC            = pc_r;
    assign PC_4          = pc_r + 32'd4;
    assign IF_Pred_Taken = pred_taken_s;
    assign Flush         = mispredict_s && !RESET;

endmodule

// File: tb/tb_if_next_pc_unit.sv
// Self-checking bench for if_next_pc_unit: expected PCs are queued when
// stimulus is driven and compared after the following clock edge.
module tb_if_next_pc_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        Stall;
    logic [31:0] IF_Instruction;
    logic [31:0] Branch_Addr;
    logic        EX_Branch;
    logic        EX_Taken;
    logic        EX_Pred_Taken;
    logic [31:0] EX_PC;
    logic [31:0] EX_Target;
    logic [31:0] PC;
    logic [31:0] PC_4;
    logic        IF_Pred_Taken;
    logic        Flush;

    localparam logic [31:0] NOP_INSTR = 32'h0001_FFFA;
    localparam logic [31:0] BEQ_INSTR = 32'h1000_0000;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;

    if_next_pc_unit dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .Stall          (Stall),
        .IF_Instruction (IF_Instruction),
        .Branch_Addr    (Branch_Addr),
        .EX_Branch      (EX_Branch),
        .EX_Taken       (EX_Taken),
        .EX_Pred_Taken  (EX_Pred_Taken),
        .EX_PC          (EX_PC),
        .EX_Target      (EX_Target),
        .PC             (PC),
        .PC_4           (PC_4),
        .IF_Pred_Taken  (IF_Pred_Taken),
        .Flush          (Flush)
    );

    always #5 CLK = ~CLK;

    task automatic set_ex(input logic br, input logic tk, input logic pt,
                          input logic [31:0] epc, input logic [31:0] tgt);
        EX_Branch = br; EX_Taken = tk; EX_Pred_Taken = pt; EX_PC = epc; EX_Target = tgt;
    endtask

    task automatic idle();
        RESET = 1'b0; Stall = 1'b0; IF_Instruction = NOP_INSTR; Branch_Addr = 32'h0;
        set_ex(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // Advance one edge and compare the PC against the oldest queued expectation.
    task automatic edge_pc(input string name);
        @(posedge CLK);
        #1;
        exp_pc = exp_q.pop_front();
        n_checks++;
        if (PC !== exp_pc) begin
            n_fail++;
            $display("FAIL %s: PC = %h, expected %h", name, PC, exp_pc);
        end
    endtask

    // Steer PC to a target with a taken-mispredict whose EX_PC aliases to index 0.
    task automatic redirect(input logic [31:0] tgt);
        idle();
        set_ex(1'b1, 1'b1, 1'b0, 32'h0000_1000, tgt);
        exp_q.push_back(tgt);
        edge_pc("redirect");
        idle();
    endtask

    task automatic test_reset();
        idle();
        RESET = 1'b1;
        IF_Instruction = BEQ_INSTR;
        set_ex(1'b1, 1'b1, 1'b0, 32'h0, 32'h500);
        #1;
        n_checks++;
        if (Flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush: Flush = %b, expected 0", Flush); end
        exp_q.push_back(32'h0);
        edge_pc("reset_pc");
        RESET = 1'b0;
        set_ex(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        n_checks++;
        if (IF_Pred_Taken !== 1'b0) begin n_fail++; $display("FAIL reset_pred: IF_Pred_Taken = %b, expected 0", IF_Pred_Taken); end
        n_checks++;
        if (PC_4 !== 32'h4) begin n_fail++; $display("FAIL reset_pc4: PC_4 = %h, expected 00000004", PC_4); end
        IF_Instruction = NOP_INSTR;
    endtask

    task automatic test_free_run();
        idle();
        for (int i = 1; i <= 3; i++) begin
            #1;
            n_checks++;
            if (IF_Pred_Taken !== 1'b0 || Flush !== 1'b0) begin
                n_fail++;
                $display("FAIL free_run_ctl: pred = %b flush = %b, expected 0 0", IF_Pred_Taken, Flush);
            end
            exp_q.push_back(32'(4 * i));
            edge_pc("free_run");
        end
    endtask

    task automatic test_train();
        // Three correct taken updates at 0x40 while stalled at 12.
        for (int i = 0; i < 3; i++) begin
            idle();
            Stall = 1'b1;
            set_ex(1'b1, 1'b1, 1'b1, 32'h40, 32'h0);
            exp_q.push_back(32'hC);
            edge_pc("train_stall");
        end
        redirect(32'h40);
        IF_Instruction = BEQ_INSTR;
        Branch_Addr = 32'h20;
        set_ex(1'b1, 1'b1, 1'b1, 32'h40, 32'h0);
        #1;
        n_checks++;
        if (IF_Pred_Taken !== 1'b1) begin n_fail++; $display("FAIL train_pred: IF_Pred_Taken = %b, expected 1", IF_Pred_Taken); end
        n_checks++;
        if (Flush !== 1'b0) begin n_fail++; $display("FAIL train_flush: Flush = %b, expected 0", Flush); end
        exp_q.push_back(32'h20);
        edge_pc("train_taken");
        // One not-taken step from saturated 11 leaves 10: still predicts taken.
        idle();
        Stall = 1'b1;
        set_ex(1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
        exp_q.push_back(32'h20);
        edge_pc("sat_stall");
        redirect(32'h40);
        IF_Instruction = BEQ_INSTR;
        Branch_Addr = 32'h20;
        set_ex(1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
        #1;
        n_checks++;
        if (IF_Pred_Taken !== 1'b1) begin n_fail++; $display("FAIL saturate_pred: IF_Pred_Taken = %b, expected 1", IF_Pred_Taken); end
        exp_q.push_back(32'h20);
        edge_pc("same_idx");
        // Counter is now 01 after the same-cycle write.
        redirect(32'h40);
        IF_Instruction = BEQ_INSTR;
        Branch_Addr = 32'h20;
        #1;
        n_checks++;
        if (IF_Pred_Taken !== 1'b0) begin n_fail++; $display("FAIL write_visible: IF_Pred_Taken = %b, expected 0", IF_Pred_Taken); end
        exp_q.push_back(32'h44);
        edge_pc("write_visible_pc");
        idle();
    endtask

    task automatic test_mispredict_taken();
        idle();
        Stall = 1'b1;
        set_ex(1'b1, 1'b1, 1'b0, 32'h200, 32'h100);
        #1;
        n_checks++;
        if (Flush !== 1'b1) begin n_fail++; $display("FAIL mp_taken_flush: Flush = %b, expected 1", Flush); end
        exp_q.push_back(32'h100);
        edge_pc("mp_taken_pc");
        idle();
    endtask

    task automatic test_mispredict_not_taken();
        idle();
        Stall = 1'b1;
        set_ex(1'b1, 1'b1, 1'b1, 32'h80, 32'h0);
        exp_q.push_back(32'h100);
        edge_pc("mp_nt_prep");
        idle();
        set_ex(1'b1, 1'b0, 1'b1, 32'h80, 32'h300);
        #1;
        n_checks++;
        if (Flush !== 1'b1) begin n_fail++; $display("FAIL mp_nt_flush: Flush = %b, expected 1", Flush); end
        exp_q.push_back(32'h84);
        edge_pc("mp_nt_pc");
        redirect(32'h80);
        IF_Instruction = BEQ_INSTR;
        Branch_Addr = 32'h400;
        #1;
        n_checks++;
        if (IF_Pred_Taken !== 1'b0) begin n_fail++; $display("FAIL mp_nt_ctr: IF_Pred_Taken = %b, expected 0", IF_Pred_Taken); end
        exp_q.push_back(32'h84);
        edge_pc("mp_nt_after");
        idle();
    endtask

    task automatic test_stall();
        redirect(32'hC);
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(32'hC);
            edge_pc("stall_hold");
        end
        Stall = 1'b0;
        exp_q.push_back(32'h10);
        edge_pc("stall_release");
    endtask

    task automatic test_wrap();
        redirect(32'hFFFF_FFFC);
        #1;
        n_checks++;
        if (PC_4 !== 32'h0) begin n_fail++; $display("FAIL pc4_wrap: PC_4 = %h, expected 00000000", PC_4); end
        exp_q.push_back(32'h0);
        edge_pc("pc_wrap");
        set_ex(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0);
        exp_q.push_back(32'h0);
        edge_pc("recovery_wrap");
        idle();
    endtask

    task automatic test_reset_redirect();
        idle();
        RESET = 1'b1;
        set_ex(1'b1, 1'b1, 1'b0, 32'h80, 32'h700);
        #1;
        n_checks++;
        if (Flush !== 1'b0) begin n_fail++; $display("FAIL rst_mp_flush: Flush = %b, expected 0", Flush); end
        exp_q.push_back(32'h0);
        edge_pc("rst_mp_pc");
        idle();
        IF_Instruction = BEQ_INSTR;
        Branch_Addr = 32'h600;
        Stall = 1'b1;
        #1;
        n_checks++;
        if (IF_Pred_Taken !== 1'b0) begin n_fail++; $display("FAIL rst_ctr0: IF_Pred_Taken = %b, expected 0", IF_Pred_Taken); end
        // One taken update at index 32 must move 01 -> 10.
        set_ex(1'b1, 1'b1, 1'b1, 32'h80, 32'h0);
        exp_q.push_back(32'h0);
        edge_pc("rst_stall");
        redirect(32'h80);
        IF_Instruction = BEQ_INSTR;
        Branch_Addr = 32'h600;
        #1;
        n_checks++;
        if (IF_Pred_Taken !== 1'b1) begin n_fail++; $display("FAIL rst_ctr32: IF_Pred_Taken = %b, expected 1", IF_Pred_Taken); end
        exp_q.push_back(32'h600);
        edge_pc("rst_pred_pc");
        idle();
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_train();
        test_mispredict_taken();
        test_mispredict_not_taken();
        test_stall();
        test_wrap();
        test_reset_redirect();
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
